// File: rtl/ex_pipe_pkg.sv
// Shared constants for the Y86 execute stage: icode/ifun encodings, branch condition
// codes, condition-code bit positions, FSM state type and the condition evaluator.
package ex_pipe_pkg;

   // Instruction codes (RRMOVL and CMOVXX share an icode; ifun 0 means unconditional)
   localparam logic [7:0] I_RRMOVL = 8'h2;
   localparam logic [7:0] I_IRMOVL = 8'h3;
   localparam logic [7:0] I_RMMOVL = 8'h4;
   localparam logic [7:0] I_MRMOVL = 8'h5;
   localparam logic [7:0] I_OPL    = 8'h6;
   localparam logic [7:0] I_JXX    = 8'h7;
   localparam logic [7:0] I_CALL   = 8'h8;
   localparam logic [7:0] I_RET    = 8'h9;
   localparam logic [7:0] I_PUSHL  = 8'hA;
   localparam logic [7:0] I_POPL   = 8'hB;

   // OPL function codes
   localparam logic [7:0] F_ADDL = 8'h0;
   localparam logic [7:0] F_SUBL = 8'h1;
   localparam logic [7:0] F_ANDL = 8'h2;
   localparam logic [7:0] F_XORL = 8'h3;
   localparam logic [7:0] F_MULL = 8'h4;

   // Jump / conditional-move function codes
   localparam logic [7:0] C_ALWAYS = 8'h0;
   localparam logic [7:0] C_LE     = 8'h1;
   localparam logic [7:0] C_L      = 8'h2;
   localparam logic [7:0] C_E      = 8'h3;
   localparam logic [7:0] C_NE     = 8'h4;
   localparam logic [7:0] C_GE     = 8'h5;
   localparam logic [7:0] C_G      = 8'h6;

   // Condition-code bit positions within {ZF,SF,OF}
   localparam int unsigned CC_ZF = 2;
   localparam int unsigned CC_SF = 1;
   localparam int unsigned CC_OF = 0;
   localparam logic [2:0]  CC_RESET = 3'b100;

   typedef enum logic [1:0] {StIdle, StRun, StWait} ex_state_e;

   function automatic logic cond_eval(input logic [7:0] ifun, input logic [2:0] cc);
      logic zf, sf, of;
      zf = cc[CC_ZF];
      sf = cc[CC_SF];
      of = cc[CC_OF];
      case (ifun)
         C_ALWAYS: cond_eval = 1'b1;
         C_LE:     cond_eval = (sf ^ of) | zf;
         C_L:      cond_eval = sf ^ of;
         C_E:      cond_eval = zf;
         C_NE:     cond_eval = ~zf;
         C_GE:     cond_eval = ~(sf ^ of);
         C_G:      cond_eval = ~(sf ^ of) & ~zf;
         default:  cond_eval = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ex_pipe_if.sv
// Handshake bundle between decode, execute and memory.
//   in_valid/in_ready + icode_i/ifun_i/valA_i/valB_i/valC_i : decode -> execute
//   out_valid/out_ready + valE_o/cnd_o                      : execute -> memory
//   cc_o, busy_o                                            : execute status
// slave modport is the execute stage; master is its environment.
interface ex_pipe_if #(parameter int unsigned WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       icode_i;
   logic [7:0]       ifun_i;
   logic [WIDTH-1:0] valA_i;
   logic [WIDTH-1:0] valB_i;
   logic [WIDTH-1:0] valC_i;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] valE_o;
   logic             cnd_o;
   logic [2:0]       cc_o;
   logic             busy_o;

   modport master (
      output in_valid, icode_i, ifun_i, valA_i, valB_i, valC_i, out_ready,
      input  in_ready, out_valid, valE_o, cnd_o, cc_o, busy_o
   );

   modport slave (
      input  in_valid, icode_i, ifun_i, valA_i, valB_i, valC_i, out_ready,
      output in_ready, out_valid, valE_o, cnd_o, cc_o, busy_o
   );
endinterface

// File: rtl/ex_mul_seq.sv
// Iterative signed WIDTH x WIDTH multiplier.
//   clk, rst  : clock, synchronous active-high reset (aborts a running multiply)
//   start     : capture a/b and begin; ignored while running
//   a, b      : signed operands
//   done      : high during the last of WIDTH shift-add cycles; prod_lo/ovf valid then
//   prod_lo   : low WIDTH bits of the signed product
//   ovf       : full product does not fit in WIDTH signed bits
module ex_mul_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] prod_lo,
   output logic             ovf
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic               run_q;
   logic [CW-1:0]      cnt_q;
   logic               neg_q;
   logic [2*WIDTH-1:0] acc_q, mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] acc_d, prod;

   // Work on magnitudes; |most-negative| still fits as an unsigned WIDTH-bit value
   assign mag_a = a[WIDTH-1] ? ('0 - a) : a;
   assign mag_b = b[WIDTH-1] ? ('0 - b) : b;

   always_comb begin
      acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
      // Sign fix-up folded into the final step so the result is ready on done
      prod    = neg_q ? ('0 - acc_d) : acc_d;
      done    = run_q && (cnt_q == CW'(WIDTH - 1));
      prod_lo = prod[WIDTH-1:0];
      ovf     = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q    <= 1'b0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else if (start && !run_q) begin
         run_q    <= 1'b1;
         cnt_q    <= '0;
         neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
         acc_q    <= '0;
         mcand_q  <= {{WIDTH{1'b0}}, mag_a};
         mplier_q <= mag_b;
      end else if (run_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CW'(1);
         if (done) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/ex_pipe.sv
// Registered Y86 execute stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ex_pipe_if.slave -- decode-side valid/ready with icode/ifun/valA/valB/valC,
//              memory-side valid/ready with valE/cnd, plus cc_o {ZF,SF,OF} and busy_o.
// Single-cycle ops register their result on the accept edge. MULL runs on ex_mul_seq
// for WIDTH cycles with the input side stalled; CC is written with the result.
module ex_pipe
   import ex_pipe_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned STACK_STEP = 4,
   parameter bit          MUL_EN     = 1'b1
) (
   input logic    clk,
   input logic    rst,
   ex_pipe_if.slave bus
);
   localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

   ex_state_e        state_q;
   logic             out_valid_q, cnd_q;
   logic [WIDTH-1:0] vale_q, pend_val_q;
   logic             pend_ovf_q;
   logic [2:0]       cc_q;

   logic [WIDTH-1:0] a, b, c, res, mul_lo;
   logic             of, cnd, cc_upd, is_mul, mul_done, mul_ovf;
   logic             out_free, in_ready, accept;
   logic [2:0]       cc_op, mul_cc, pend_cc;

   assign out_free = !out_valid_q || bus.out_ready;
   assign in_ready = (state_q == StIdle) && out_free;
   assign accept   = bus.in_valid && in_ready;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.valE_o    = vale_q;
   assign bus.cnd_o     = cnd_q;
   assign bus.cc_o      = cc_q;
   assign bus.busy_o    = (state_q != StIdle);

   always_comb begin
      a      = bus.valA_i;
      b      = bus.valB_i;
      c      = bus.valC_i;
      res    = '0;
      of     = 1'b0;
      cnd    = 1'b0;
      cc_upd = 1'b0;
      is_mul = 1'b0;
      case (bus.icode_i)
         I_OPL: begin
            case (bus.ifun_i)
               F_ADDL: begin
                  res    = b + a;
                  of     = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
                  cc_upd = 1'b1;
               end
               F_SUBL: begin
                  res    = b - a;
                  of     = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != b[WIDTH-1]);
                  cc_upd = 1'b1;
               end
               F_ANDL: begin
                  res    = b & a;
                  cc_upd = 1'b1;
               end
               F_XORL: begin
                  res    = b ^ a;
                  cc_upd = 1'b1;
               end
               F_MULL:  is_mul = MUL_EN;
               default: ;
            endcase
         end
         I_IRMOVL:          res = c;
         I_RMMOVL, I_MRMOVL: res = b + c;
         I_CALL, I_PUSHL:   res = b - STEP;
         I_RET, I_POPL:     res = b + STEP;
         I_RRMOVL: begin
            res = a;
            cnd = cond_eval(bus.ifun_i, cc_q);
         end
         I_JXX:   cnd = cond_eval(bus.ifun_i, cc_q);
         default: ;
      endcase
      cc_op   = {res == '0, res[WIDTH-1], of};
      mul_cc  = {mul_lo == '0, mul_lo[WIDTH-1], mul_ovf};
      pend_cc = {pend_val_q == '0, pend_val_q[WIDTH-1], pend_ovf_q};
   end

   ex_mul_seq #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (accept && is_mul),
      .a      (a),
      .b      (b),
      .done   (mul_done),
      .prod_lo(mul_lo),
      .ovf    (mul_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         out_valid_q <= 1'b0;
         vale_q      <= '0;
         cnd_q       <= 1'b0;
         cc_q        <= CC_RESET;
         pend_val_q  <= '0;
         pend_ovf_q  <= 1'b0;
      end else begin
         // Drain first; any write below in the same cycle refills the slot
         if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (accept) begin
                  if (is_mul) begin
                     state_q <= StRun;
                  end else begin
                     out_valid_q <= 1'b1;
                     vale_q      <= res;
                     cnd_q       <= cnd;
                     if (cc_upd) cc_q <= cc_op;
                  end
               end
            end
            StRun: begin
               if (mul_done) begin
                  if (out_free) begin
                     out_valid_q <= 1'b1;
                     vale_q      <= mul_lo;
                     cnd_q       <= 1'b0;
                     cc_q        <= mul_cc;
                     state_q     <= StIdle;
                  end else begin
                     pend_val_q <= mul_lo;
                     pend_ovf_q <= mul_ovf;
                     state_q    <= StWait;
                  end
               end
            end
            StWait: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b1;
                  vale_q      <= pend_val_q;
                  cnd_q       <= 1'b0;
                  cc_q        <= pend_cc;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
